// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the board power-rail sequencer: state encodings
// and default timing constants derived from the 32.768 kHz sequencing clock.
package pwr_seq_pkg;

   // Sequencer states; the numeric values are visible on the debug/readback port
   typedef enum logic [2:0] {
      SEQ_OFF     = 3'd0,
      SEQ_WAIT_PG = 3'd1,
      SEQ_ON_DLY  = 3'd2,
      SEQ_ON      = 3'd3,
      SEQ_OFF_DLY = 3'd4,
      SEQ_FAULT   = 3'd5
   } seq_state_e;

   // Sequencing clock frequency in Hz
   localparam int CLK_HZ = 32768;

   // ~100 ms power-good timeout, rounded to the nearest cycle (3277)
   localparam int PG_TIMEOUT_100MS = (CLK_HZ * 100 + 500) / 1000;

   // ~1 ms inter-rail delay, rounded to the nearest cycle (33)
   localparam int DLY_1MS = (CLK_HZ + 500) / 1000;

endpackage

// File: rtl/pwr_rail_seq_pg_sync.sv
// Two-flop synchronizer bringing the asynchronous board power-good pins
// into the 32 kHz domain. Resets to "not good" so nothing looks powered
// while the sequencer is held in reset.
module pg_sync #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk_32k,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; second stage gives it a full cycle to settle
   always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta   <= '0;
         o_sync <= '0;
      end else begin
         meta   <= i_async;
         o_sync <= meta;
      end
   end

endmodule

// File: rtl/pwr_rail_seq.sv
// Board power-rail sequencer. Brings rails up in ascending order behind PSON,
// gating each step on that rail's power-good with a settle delay and a
// timeout, and takes them down in descending order when PSON drops. Timeouts
// and power-good loss are latched as faults that kill every rail at once.
module pwr_rail_seq
   import pwr_seq_pkg::*;
#(
   parameter int NUM_RAILS  = 4,
   parameter int CNT_W      = 12,
   parameter int PG_TIMEOUT = PG_TIMEOUT_100MS,
   parameter int DLY_ON     = DLY_1MS,
   parameter int DLY_OFF    = DLY_1MS
) (
   input  logic                 i_clk_32k,
   input  logic                 i_rst_n,
   input  logic                 i_ctrl_PSON,
   input  logic [NUM_RAILS-1:0] i_pwr_good,
   input  logic                 i_fault_clr,
   output logic [NUM_RAILS-1:0] o_rail_en,
   output logic                 o_sys_pwrok,
   output logic                 o_fault,
   output logic [2:0]           o_fault_rail,
   output logic [2:0]           o_seq_state
);

   localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PG_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DLY_ON_LAST  = CNT_W'(DLY_ON - 1);
   localparam logic [CNT_W-1:0] DLY_OFF_LAST = CNT_W'(DLY_OFF - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_RAILS - 1);

   seq_state_e           state;
   seq_state_e           state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic [NUM_RAILS-1:0] rail_en_nxt;
   logic [2:0]           fault_rail_nxt;
   logic [NUM_RAILS-1:0] pg;
   logic                 pg_lost;
   logic [IDX_W-1:0]     lost_idx;

   pg_sync #(
      .WIDTH (NUM_RAILS)
   ) u_pg_sync (
      .i_clk_32k (i_clk_32k),
      .i_rst_n   (i_rst_n),
      .i_async   (i_pwr_good),
      .o_sync    (pg)
   );

   // Find the lowest-numbered enabled rail whose power-good has dropped
   always_comb begin
      pg_lost  = 1'b0;
      lost_idx = '0;
      for (int i = NUM_RAILS - 1; i >= 0; i--) begin
         if (o_rail_en[i] && !pg[i]) begin
            pg_lost  = 1'b1;
            lost_idx = IDX_W'(i);
         end
      end
   end

   // Next-state and enable/fault-rail decisions; faults win over PSON drop,
   // which wins over normal sequence progress
   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      rail_en_nxt    = o_rail_en;
      fault_rail_nxt = o_fault_rail;

      case (state)
         SEQ_OFF: begin
            rail_en_nxt = '0;
            if (i_ctrl_PSON) begin
               rail_en_nxt[0] = 1'b1;
               idx_nxt        = '0;
               state_nxt      = SEQ_WAIT_PG;
            end
         end

         SEQ_WAIT_PG: begin
            if (!pg[idx] && (cnt == TIMEOUT_LAST)) begin
               state_nxt      = SEQ_FAULT;
               fault_rail_nxt = 3'(idx);
            end else if (!i_ctrl_PSON) begin
               state_nxt = SEQ_OFF_DLY;
            end else if (pg[idx]) begin
               state_nxt = (idx == LAST_IDX) ? SEQ_ON : SEQ_ON_DLY;
            end
         end

         SEQ_ON_DLY: begin
            if (!i_ctrl_PSON) begin
               state_nxt = SEQ_OFF_DLY;
            end else if (cnt == DLY_ON_LAST) begin
               idx_nxt              = idx + IDX_W'(1);
               rail_en_nxt[idx_nxt] = 1'b1;
               state_nxt            = SEQ_WAIT_PG;
            end
         end

         SEQ_ON: begin
            if (pg_lost) begin
               state_nxt      = SEQ_FAULT;
               fault_rail_nxt = 3'(lost_idx);
            end else if (!i_ctrl_PSON) begin
               state_nxt = SEQ_OFF_DLY;
            end
         end

         SEQ_OFF_DLY: begin
            rail_en_nxt[idx] = 1'b0;
            if (cnt == DLY_OFF_LAST) begin
               if (idx == '0) begin
                  state_nxt = SEQ_OFF;
               end else begin
                  idx_nxt = idx - IDX_W'(1);
               end
            end
         end

         SEQ_FAULT: begin
            rail_en_nxt = '0;
            if (i_fault_clr && !i_ctrl_PSON) begin
               state_nxt = SEQ_OFF;
            end
         end

         default: begin
            state_nxt      = SEQ_FAULT;
            fault_rail_nxt = '0;
         end
      endcase

      if (state_nxt == SEQ_FAULT) begin
         rail_en_nxt = '0;
      end
   end

   // Shared delay/timeout counter restarts whenever the step changes and parks at all-ones
   always_comb begin
      if ((state_nxt != state) || (idx_nxt != idx)) begin
         cnt_nxt = '0;
      end else if (&cnt) begin
         cnt_nxt = cnt;
      end else begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // State, step index, counter and registered outputs; reset drops every rail at once
   always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= SEQ_OFF;
         idx          <= '0;
         cnt          <= '0;
         o_rail_en    <= '0;
         o_sys_pwrok  <= 1'b0;
         o_fault      <= 1'b0;
         o_fault_rail <= '0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         cnt          <= cnt_nxt;
         o_rail_en    <= rail_en_nxt;
         o_sys_pwrok  <= (state_nxt == SEQ_ON);
         o_fault      <= (state_nxt == SEQ_FAULT);
         o_fault_rail <= fault_rail_nxt;
      end
   end

   assign o_seq_state = state;

endmodule
